// File: rtl/panel_sequencer_pkg.sv
// Shared opcodes, FSM states and panel-pulse bit positions for panel_sequencer.
// Step word layout: {opcode[3:0], operand[11:0], delay[DELAY_W-1:0]}.
package panel_sequencer_pkg;

  localparam int OP_W   = 4;
  localparam int OPND_W = 12;
  localparam int SR_W   = 12;

  localparam logic [OP_W-1:0] OP_NOP      = 4'd0;
  localparam logic [OP_W-1:0] OP_SETSR    = 4'd1;
  localparam logic [OP_W-1:0] OP_ADDRLD   = 4'd2;
  localparam logic [OP_W-1:0] OP_EXTD     = 4'd3;
  localparam logic [OP_W-1:0] OP_DEP      = 4'd4;
  localparam logic [OP_W-1:0] OP_EXAM     = 4'd5;
  localparam logic [OP_W-1:0] OP_CONT     = 4'd6;
  localparam logic [OP_W-1:0] OP_HALT     = 4'd7;
  localparam logic [OP_W-1:0] OP_WAITHALT = 4'd8;
  localparam logic [OP_W-1:0] OP_WAITADDR = 4'd9;
  localparam logic [OP_W-1:0] OP_CHKADDR  = 4'd10;
  localparam logic [OP_W-1:0] OP_PASS     = 4'd14;
  localparam logic [OP_W-1:0] OP_FAIL     = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_PULSE,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int PB_ADDRLD = 0;
  localparam int PB_EXTD   = 1;
  localparam int PB_DEP    = 2;
  localparam int PB_EXAM   = 3;
  localparam int PB_CONT   = 4;
  localparam int NPULSE    = 5;

  // One-hot panel pulse for a pulse opcode; all-zero for anything else.
  function automatic logic [NPULSE-1:0] pulse_sel(input logic [OP_W-1:0] op);
    logic [NPULSE-1:0] sel;
    sel = '0;
    case (op)
      OP_ADDRLD: sel[PB_ADDRLD] = 1'b1;
      OP_EXTD:   sel[PB_EXTD]   = 1'b1;
      OP_DEP:    sel[PB_DEP]    = 1'b1;
      OP_EXAM:   sel[PB_EXAM]   = 1'b1;
      OP_CONT:   sel[PB_CONT]   = 1'b1;
      default:   sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/panel_sequencer_if.sv
// Host/CPU-facing bundle of panel_sequencer: step-memory writes, run control,
// CPU status in, panel switch/pulse levels and run status out.
interface panel_sequencer_if
  import panel_sequencer_pkg::*;
#(
  parameter int NSTEPS  = 16,
  parameter int DELAY_W = 16,
  parameter int ADDR_W  = 15
);
  localparam int IDX_W = $clog2(NSTEPS);

  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [15+DELAY_W:0] wr_data;
  logic               start;
  logic               abort;
  logic [ADDR_W-1:0]  cpu_address;
  logic               cpu_halted;

  logic [SR_W-1:0]    sr;
  logic               addr_load;
  logic               extd_addr;
  logic               dep;
  logic               exam;
  logic               cont;
  logic               halt;
  logic               busy;
  logic               pass;
  logic               fail;
  logic [IDX_W-1:0]   step_idx;

  modport master (
    output wr_en, wr_addr, wr_data, start, abort, cpu_address, cpu_halted,
    input  sr, addr_load, extd_addr, dep, exam, cont, halt, busy, pass, fail, step_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, abort, cpu_address, cpu_halted,
    output sr, addr_load, extd_addr, dep, exam, cont, halt, busy, pass, fail, step_idx
  );

endinterface

// File: rtl/panel_sequencer_pulse_gen.sv
// Shared down-counter timing both the panel pulse width and the post-step gap.
// A load of N makes last_o rise on the N-th cycle after the load edge.
module panel_sequencer_pulse_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/panel_sequencer.sv
// Front-panel stimulus engine: replays programmed panel steps into the PDP8e and
// reports pass/fail. Define PANEL_SEQ_TIMEOUT_EN to add a 24-bit WAIT watchdog.
module panel_sequencer
  import panel_sequencer_pkg::*;
#(
  parameter int NSTEPS  = 16,
  parameter int DELAY_W = 16,
  parameter int PULSE_W = 1700,
  parameter int ADDR_W  = 15
) (
  input logic              clk,
  input logic              resetn,
  panel_sequencer_if.slave bus
);

  localparam int IDX_W    = $clog2(NSTEPS);
  localparam int WORD_W   = OP_W + OPND_W + DELAY_W;
  localparam int OPC_LSB  = DELAY_W + OPND_W;
  localparam int OPND_LSB = DELAY_W;
  localparam int PW_W     = $clog2(PULSE_W + 1);
  localparam int CNT_W    = (DELAY_W > PW_W) ? DELAY_W : PW_W;

  logic [WORD_W-1:0] mem_q [NSTEPS];
  logic [WORD_W-1:0] fetch_word;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [OPND_W-1:0]   opnd_q, opnd_d;
  logic [DELAY_W-1:0]  dly_q, dly_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [NPULSE-1:0]   pls_q, pls_d;
  logic                halt_q, halt_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;

  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_val;
  logic                cnt_last;
  logic                step_end;
  logic                advance;
  logic                set_fail;
  logic                wait_hit;
  logic                wd_exp;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^bus.cpu_address[ADDR_W-1:OPND_W];

  // Step memory is only writable while idle so a running program never changes under itself.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (state_q == ST_IDLE)) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign fetch_word = mem_q[idx_q];
  assign wait_hit   = (op_q == OP_WAITHALT) ? bus.cpu_halted
                                            : (bus.cpu_address[OPND_W-1:0] == opnd_q);

`ifdef PANEL_SEQ_TIMEOUT_EN
  logic [23:0] wd_q, wd_d;

  assign wd_d   = (state_q == ST_WAIT) ? wd_q + 24'd1 : 24'd0;
  assign wd_exp = (state_q == ST_WAIT) && (wd_q == 24'hFF_FFFF);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_exp = 1'b0;
`endif

  panel_sequencer_pulse_gen #(.CNT_W(CNT_W)) u_pulse_gen (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    dly_d    = dly_q;
    sr_d     = sr_q;
    pls_d    = '0;
    halt_d   = halt_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    cnt_load = 1'b0;
    cnt_val  = CNT_W'(PULSE_W);
    step_end = 1'b0;
    advance  = 1'b0;
    set_fail = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
          idx_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      ST_FETCH: begin
        op_d    = fetch_word[OPC_LSB +: OP_W];
        opnd_d  = fetch_word[OPND_LSB +: OPND_W];
        dly_d   = fetch_word[0 +: DELAY_W];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (op_q)
          OP_NOP:   step_end = 1'b1;
          OP_SETSR: begin
            sr_d     = opnd_q;
            step_end = 1'b1;
          end
          OP_ADDRLD, OP_EXTD, OP_DEP, OP_EXAM, OP_CONT: begin
            pls_d    = pulse_sel(op_q);
            cnt_load = 1'b1;
            state_d  = ST_PULSE;
          end
          OP_HALT: begin
            halt_d   = opnd_q[OPND_W-1];
            step_end = 1'b1;
          end
          OP_WAITHALT, OP_WAITADDR: state_d = ST_WAIT;
          OP_CHKADDR: begin
            if (bus.cpu_address[OPND_W-1:0] == opnd_q) step_end = 1'b1;
            else                                        set_fail = 1'b1;
          end
          OP_PASS: begin
            state_d = ST_DONE;
            pass_d  = 1'b1;
            fail_d  = 1'b0;
          end
          default: set_fail = 1'b1;
        endcase
      end
      ST_PULSE: begin
        if (cnt_last) step_end = 1'b1;
        else          pls_d    = pls_q;
      end
      ST_WAIT: begin
        if (wait_hit) begin
          step_end = 1'b1;
        end else if (wd_exp) begin
          set_fail = 1'b1;
          halt_d   = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_last) advance = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A zero delay skips GAP; running off the last step without PASS/FAIL is a failure.
    if (step_end) begin
      if (dly_q != '0) begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(dly_q);
        state_d  = ST_GAP;
      end else begin
        advance = 1'b1;
      end
    end
    if (advance) begin
      if (idx_q == IDX_W'(NSTEPS - 1)) begin
        set_fail = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_FETCH;
      end
    end
    if (set_fail) begin
      state_d = ST_DONE;
      fail_d  = 1'b1;
      pass_d  = 1'b0;
    end

    if (bus.abort) begin
      state_d  = (state_q == ST_IDLE) ? ST_IDLE : ST_DONE;
      idx_d    = idx_q;
      pls_d    = '0;
      cnt_load = 1'b0;
      halt_d   = 1'b1;
      fail_d   = 1'b1;
      pass_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      op_q    <= OP_NOP;
      opnd_q  <= '0;
      dly_q   <= '0;
      sr_q    <= '0;
      pls_q   <= '0;
      halt_q  <= 1'b1;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      dly_q   <= dly_d;
      sr_q    <= sr_d;
      pls_q   <= pls_d;
      halt_q  <= halt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.sr        = sr_q;
  assign bus.addr_load = pls_q[PB_ADDRLD];
  assign bus.extd_addr = pls_q[PB_EXTD];
  assign bus.dep       = pls_q[PB_DEP];
  assign bus.exam      = pls_q[PB_EXAM];
  assign bus.cont      = pls_q[PB_CONT];
  assign bus.halt      = halt_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.step_idx  = idx_q;

endmodule

// File: tb/tb_panel_sequencer.sv
// Scoreboard bench for panel_sequencer: sr changes, pulse widths and run results
// are queued as stimulus is programmed and compared as the DUT produces them.
module tb_panel_sequencer;
  import panel_sequencer_pkg::*;

  localparam int NSTEPS  = 16;
  localparam int DELAY_W = 16;
  localparam int PULSE_W = 1700;
  localparam int ADDR_W  = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  panel_sequencer_if #(.NSTEPS(NSTEPS), .DELAY_W(DELAY_W), .ADDR_W(ADDR_W)) bus ();

  panel_sequencer #(
    .NSTEPS(NSTEPS), .DELAY_W(DELAY_W), .PULSE_W(PULSE_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk    (clk),
    .resetn (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] exp_sr[$];
  int          exp_pid[$];
  int          exp_pw[$];
  logic [5:0]  exp_res[$];

  logic [NPULSE-1:0] pv;
  assign pv = {bus.cont, bus.exam, bus.dep, bus.extd_addr, bus.addr_load};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic wr_step(input int idx, input logic [3:0] op, input logic [11:0] opnd,
                         input logic [15:0] dly);
    @(posedge clk); #1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(idx);
    bus.wr_data = {op, opnd, dly};
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_seq();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, output int ncyc);
    int i;
    ncyc = 0;
    i    = 0;
    while (i < budget) begin
      @(negedge clk);
      if (!bus.busy) break;
      ncyc++;
      i++;
    end
    if (bus.busy) check(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_pulse(input string tag, input int bitn, input int budget);
    int i;
    i = 0;
    while (i < budget) begin
      @(negedge clk);
      if (pv[bitn]) break;
      i++;
    end
    if (!pv[bitn]) check(tag, 32'(pv[bitn]), 32'd1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT produces an observable event.
  initial begin : monitor
    logic [11:0] prev_sr;
    logic        prev_busy;
    int          w[NPULSE];
    prev_sr   = '0;
    prev_busy = 1'b0;
    foreach (w[i]) w[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sr   = bus.sr;
        prev_busy = bus.busy;
        foreach (w[i]) w[i] = 0;
      end else begin
        if (bus.sr !== prev_sr) begin
          if (exp_sr.size() == 0) check("sr_extra", 32'(bus.sr), 32'(prev_sr));
          else                    check("sr_seq", 32'(bus.sr), 32'(exp_sr.pop_front()));
          prev_sr = bus.sr;
        end
        if ($countones(pv) > 1) check("pulse_onehot", 32'($countones(pv)), 32'd1);
        for (int i = 0; i < NPULSE; i++) begin
          if (pv[i]) begin
            w[i]++;
          end else if (w[i] > 0) begin
            if (exp_pid.size() == 0) begin
              check("pulse_extra", 32'(w[i]), 32'd0);
            end else begin
              check("pulse_id", 32'(i), 32'(exp_pid.pop_front()));
              check("pulse_width", 32'(w[i]), 32'(exp_pw.pop_front()));
            end
            w[i] = 0;
          end
        end
        if (prev_busy && !bus.busy) begin
          check("pass_fail_excl", 32'(bus.pass & bus.fail), 32'd0);
          if (exp_res.size() == 0) check("result_extra", 32'(bus.busy), 32'd1);
          else check("result", 32'({bus.pass, bus.fail, bus.step_idx}), 32'(exp_res.pop_front()));
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : stim
    int n;
    rst_n           = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_halted  = 1'b0;
    #22;
    check("rst_sr",    32'(bus.sr), 32'd0);
    check("rst_pulse", 32'(pv), 32'd0);
    check("rst_halt",  32'(bus.halt), 32'd1);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_pass",  32'(bus.pass), 32'd0);
    check("rst_fail",  32'(bus.fail), 32'd0);
    check("rst_idx",   32'(bus.step_idx), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: SETSR / ADDRLD (with gap) / SETSR / CONT / PASS
    wr_step(0, OP_SETSR, 12'o0200, 16'd0);
    wr_step(1, OP_ADDRLD, 12'o0000, 16'd25);
    wr_step(2, OP_SETSR, 12'o7777, 16'd0);
    wr_step(3, OP_CONT, 12'o0000, 16'd0);
    wr_step(4, OP_PASS, 12'o0000, 16'd0);
    exp_sr.push_back(12'o0200);
    exp_sr.push_back(12'o7777);
    exp_pid.push_back(PB_ADDRLD); exp_pw.push_back(PULSE_W);
    exp_pid.push_back(PB_CONT);   exp_pw.push_back(PULSE_W);
    exp_res.push_back({1'b1, 1'b0, 4'd4});
    start_seq();
    wait_idle("t1_idle", 10000, n);
    check("t1_latency", 32'(n), 32'd3436);
    check("t1_halt", 32'(bus.halt), 32'd1);

    // Test 2: HALT 0, WAITADDR 5276, write while busy must be dropped
    wr_step(0, OP_HALT, 12'o0000, 16'd0);
    wr_step(1, OP_WAITADDR, 12'o5276, 16'd0);
    wr_step(2, OP_PASS, 12'o0000, 16'd0);
    exp_res.push_back({1'b1, 1'b0, 4'd2});
    start_seq();
    wr_step(2, OP_FAIL, 12'o0000, 16'd0);
    bus.cpu_address = 15'o15277;
    repeat (2996) @(posedge clk);
    #1;
    check("t2_busy_in_wait", 32'(bus.busy), 32'd1);
    check("t2_halt_low", 32'(bus.halt), 32'd0);
    bus.cpu_address = 15'o05276;
    @(negedge clk);
    check("t2_still_wait", 32'(bus.step_idx), 32'd1);
    @(negedge clk);
    check("t2_left_wait", 32'(bus.step_idx), 32'd2);
    wait_idle("t2_idle", 100, n);
    bus.cpu_address = '0;

    // Test 3: illegal opcode 12 at step 3
    for (int i = 0; i < 3; i++) wr_step(i, OP_NOP, 12'o0000, 16'd0);
    wr_step(3, 4'd12, 12'o0000, 16'd0);
    wr_step(4, OP_PASS, 12'o0000, 16'd0);
    exp_res.push_back({1'b0, 1'b1, 4'd3});
    start_seq();
    wait_idle("t3_idle", 100, n);
    check("t3_latency", 32'(n), 32'd9);
    check("t3_pulses", 32'(pv), 32'd0);

    // Test 4: abort with simultaneous start during CONT pulse cycle 500
    wr_step(0, OP_CONT, 12'o0000, 16'd0);
    wr_step(1, OP_PASS, 12'o0000, 16'd0);
    exp_pid.push_back(PB_CONT); exp_pw.push_back(500);
    exp_res.push_back({1'b0, 1'b1, 4'd0});
    start_seq();
    wait_pulse("t4_cont_rise", PB_CONT, 20);
    repeat (499) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("t4_cont_drop", 32'(bus.cont), 32'd0);
    check("t4_halt", 32'(bus.halt), 32'd1);
    check("t4_fail", 32'(bus.fail), 32'd1);
    check("t4_pass", 32'(bus.pass), 32'd0);
    wait_idle("t4_idle", 10, n);
    repeat (3) @(negedge clk);
    check("t4_start_ignored", 32'(bus.busy), 32'd0);
    check("t4_fail_kept", 32'(bus.fail), 32'd1);

    // Test 5: 16 NOPs wrap, then reset mid-pulse
    for (int i = 0; i < NSTEPS; i++) wr_step(i, OP_NOP, 12'o0000, 16'd0);
    exp_res.push_back({1'b0, 1'b1, 4'd15});
    start_seq();
    wait_idle("t5_wrap_idle", 200, n);
    check("t5_latency", 32'(n), 32'd33);
    wr_step(0, OP_SETSR, 12'o1234, 16'd0);
    wr_step(1, OP_EXAM, 12'o0000, 16'd0);
    exp_sr.push_back(12'o1234);
    start_seq();
    wait_pulse("t5_exam_rise", PB_EXAM, 20);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_pulse", 32'(pv), 32'd0);
    check("t5_rst_sr",    32'(bus.sr), 32'd0);
    check("t5_rst_halt",  32'(bus.halt), 32'd1);
    check("t5_rst_busy",  32'(bus.busy), 32'd0);
    check("t5_rst_fail",  32'(bus.fail), 32'd0);
    check("t5_rst_idx",   32'(bus.step_idx), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 6: WAITHALT with CPU never halting blocks until abort
    wr_step(0, OP_WAITHALT, 12'o0000, 16'd0);
    bus.cpu_halted = 1'b0;
    start_seq();
    repeat (5000) @(negedge clk);
    check("t6_blocked", 32'(bus.busy), 32'd1);
    check("t6_idx", 32'(bus.step_idx), 32'd0);
    exp_res.push_back({1'b0, 1'b1, 4'd0});
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    wait_idle("t6_idle", 10, n);

    repeat (5) @(negedge clk);
    check("sb_sr_empty",    32'(exp_sr.size()), 32'd0);
    check("sb_pulse_empty", 32'(exp_pid.size()), 32'd0);
    check("sb_res_empty",   32'(exp_res.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
